mem_access_unit: RTL and testbench

- Memory-stage load/store unit sitting directly downstream of the pipeline datapath.
- Consumes the M-stage ALU result as the address and the forwarded store data.
- Drives a req/ack data bus, formats byte/halfword/word transfers, and returns extended load data for the M->W register.
- Asserts a stall while a bus transaction is outstanding, and flags misaligned addresses and bus timeouts.

---
 rtl/mem_access_unit_pkg.sv | 26 ++
 rtl/mem_access_unit_if.sv | 23 ++
 rtl/mem_access_unit_format.sv | 59 +++++
 rtl/mem_access_unit.sv | 103 ++++++++++
 tb/tb_mem_access_unit.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory-stage load/store unit: access-kind encoding,
// FSM state encoding and the store predicate.
package mem_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LBU = 3'd1,
    LH  = 3'd2,
    LHU = 3'd3,
    LW  = 3'd4,
    SB  = 3'd5,
    SH  = 3'd6,
    SW  = 3'd7
  } memOpE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } stateE;

  function automatic logic isStore(input logic [2:0] op);
    return op >= 3'd5;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/acknowledge data bus between the load/store unit (master) and memory (slave).
// One outstanding request; the request is held until bus_ack or abort.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_wstrb;
  logic [31:0]       bus_wdata;
  logic [31:0]       bus_rdata;
  logic              bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_access_unit_format.sv
// Combinational access formatting: alignment check, store strobes/lane replication
// for the issuing op, and sign/zero extension of the read word for the captured op.
module mem_format
  import mem_pkg::*;
(
  input  logic [2:0]  memop,
  input  logic [1:0]  addrLo,
  input  logic [31:0] storeData,
  input  logic [2:0]  ldOp,
  input  logic [1:0]  ldAddrLo,
  input  logic [31:0] busWord,
  output logic        aligned,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] loadData
);
  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    aligned = 1'b1;
    wstrb   = 4'b0000;
    wdata   = storeData;
    case (memop)
      LH, LHU: aligned = ~addrLo[0];
      LW:      aligned = (addrLo == 2'b00);
      SB: begin
        wstrb = 4'b0001 << addrLo;
        wdata = {4{storeData[7:0]}};
      end
      SH: begin
        aligned = ~addrLo[0];
        wstrb   = 4'b0011 << addrLo;
        wdata   = {2{storeData[15:0]}};
      end
      SW: begin
        aligned = (addrLo == 2'b00);
        wstrb   = 4'b1111;
      end
      default: ;
    endcase
  end

  // Extension uses the op/offset latched at issue, so it is independent of the pipeline inputs.
  always_comb begin
    byteSel  = busWord[{ldAddrLo, 3'b000} +: 8];
    halfSel  = ldAddrLo[1] ? busWord[31:16] : busWord[15:0];
    loadData = 32'h0;
    case (ldOp)
      LB:      loadData = {{24{byteSel[7]}}, byteSel};
      LBU:     loadData = {24'h0, byteSel};
      LH:      loadData = {{16{halfSel[15]}}, halfSel};
      LHU:     loadData = {16'h0, halfSel};
      LW:      loadData = busWord;
      default: loadData = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage load/store unit: IDLE -> REQ (until ack or timeout) -> DONE, min 3 cycles.
// Stalls the pipeline while a bus access is outstanding; misaligned accesses never reach the bus.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               memenM,
  input  logic [2:0]         memopM,
  input  logic [31:0]        aluoutM,
  input  logic [31:0]        writedataM,
  output logic [31:0]        readdataM,
  output logic               stallM,
  output logic               adelM,
  output logic               adesM,
  output logic               buserrM,
  mem_access_unit_if.master  bus
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  stateE             state;
  logic [CW-1:0]     waitCnt;
  logic [2:0]        opReg;
  logic [1:0]        addrLoReg;
  logic [31:0]       rdReg;
  logic              aligned;
  logic [3:0]        fmtStrb;
  logic [31:0]       fmtWdata;
  logic [31:0]       fmtLoad;
  logic [ADDR_W-1:0] fullAddr;

  mem_format u_format (
    .memop     (memopM),
    .addrLo    (aluoutM[1:0]),
    .storeData (writedataM),
    .ldOp      (opReg),
    .ldAddrLo  (addrLoReg),
    .busWord   (bus.bus_rdata),
    .aligned   (aligned),
    .wstrb     (fmtStrb),
    .wdata     (fmtWdata),
    .loadData  (fmtLoad)
  );

  assign fullAddr  = ADDR_W'(aluoutM);
  assign readdataM = rdReg;
  assign stallM    = memenM & aligned & (state != DONE);
  assign adelM     = memenM & ~aligned & ~isStore(memopM);
  assign adesM     = memenM & ~aligned &  isStore(memopM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      waitCnt       <= '0;
      opReg         <= 3'd0;
      addrLoReg     <= 2'd0;
      rdReg         <= 32'h0;
      buserrM       <= 1'b0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wstrb <= 4'b0000;
      bus.bus_wdata <= 32'h0;
    end else begin
      buserrM <= 1'b0;
      case (state)
        IDLE: begin
          if (memenM && aligned) begin
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= isStore(memopM);
            bus.bus_addr  <= fullAddr & ~ADDR_W'(3);
            bus.bus_wstrb <= fmtStrb;
            bus.bus_wdata <= fmtWdata;
            opReg         <= memopM;
            addrLoReg     <= aluoutM[1:0];
            waitCnt       <= '0;
            state         <= REQ;
          end
        end
        REQ: begin
          if (bus.bus_ack) begin
            rdReg       <= fmtLoad;
            bus.bus_req <= 1'b0;
            state       <= DONE;
          end else if ((TIMEOUT != 0) && (waitCnt == CW'(TIMEOUT - 1))) begin
            rdReg       <= 32'h0;
            buserrM     <= 1'b1;
            bus.bus_req <= 1'b0;
            state       <= DONE;
          end else begin
            waitCnt <= waitCnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized and directed bench for mem_access_unit against a behavioural
// access model (alignment, strobes, lane data, extension, timeout).
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        memenM;
  logic [2:0]  memopM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic [31:0] readdataM;
  logic        stallM;
  logic        adelM;
  logic        adesM;
  logic        buserrM;

  int total = 0;
  int passCnt = 0;

  // observations recorded by the access drivers
  logic        issAdel, issAdes, issStall, issReq;
  int          stallCycles, reqCycles;
  logic [31:0] fAddr, fWdata;
  logic [3:0]  fStrb;
  logic        fWe;
  bit          stable, hung, anyReq, anyStall;
  logic        doneStall, doneErr, afterErr, afterReq, afterStall;
  logic [31:0] doneRd;

  mem_access_unit_if #(.ADDR_W(32)) bus ();

  mem_access_unit #(.TIMEOUT(TO), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .memenM     (memenM),
    .memopM     (memopM),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .readdataM  (readdataM),
    .stallM     (stallM),
    .adelM      (adelM),
    .adesM      (adesM),
    .buserrM    (buserrM),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  function automatic bit mAligned(input logic [2:0] op, input logic [31:0] a);
    if (op == 3'd4 || op == 3'd7) return (a % 4) == 0;
    if (op == 3'd2 || op == 3'd3 || op == 3'd6) return (a % 2) == 0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] mStrb(input logic [2:0] op, input logic [31:0] a);
    if (op == 3'd5) return 4'(1 << (a % 4));
    if (op == 3'd6) return 4'(3 << (a % 4));
    if (op == 3'd7) return 4'd15;
    return 4'd0;
  endfunction

  function automatic logic [31:0] mWdata(input logic [2:0] op, input logic [31:0] wd);
    if (op == 3'd5) return (wd & 32'hFF) * 32'h01010101;
    if (op == 3'd6) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] mLoad(input logic [2:0] op, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> ((a % 4) * 8)) & 32'hFF;
    h = (rd >> (((a % 4) / 2) * 16)) & 32'hFFFF;
    case (op)
      3'd0:    return (b >= 128) ? (b | 32'hFFFFFF00) : b;
      3'd1:    return b;
      3'd2:    return (h >= 32768) ? (h | 32'hFFFF0000) : h;
      3'd3:    return h;
      3'd4:    return rd;
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- drivers ----------------
  // aligned access; ackAt = REQ cycle (1-based) in which bus_ack is driven, 0 = never
  task automatic access(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int ackAt);
    stallCycles = 0; reqCycles = 0; stable = 1; hung = 1;
    @(posedge clk); #1;
    memenM = 1'b1; memopM = op; aluoutM = a; writedataM = wd;
    bus.bus_ack = 1'b0; bus.bus_rdata = rd;
    @(negedge clk);
    issAdel = adelM; issAdes = adesM; issStall = stallM; issReq = bus.bus_req;
    if (stallM) stallCycles++;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      bus.bus_ack = (c == ackAt);
      @(negedge clk);
      if (!bus.bus_req) begin
        hung = 0;
        break;
      end
      reqCycles++;
      if (stallM) stallCycles++;
      if (reqCycles == 1) begin
        fAddr = bus.bus_addr; fStrb = bus.bus_wstrb; fWdata = bus.bus_wdata; fWe = bus.bus_we;
      end else if (fAddr !== bus.bus_addr || fStrb !== bus.bus_wstrb ||
                   fWdata !== bus.bus_wdata || fWe !== bus.bus_we) begin
        stable = 0;
      end
    end
    doneStall = stallM; doneRd = readdataM; doneErr = buserrM;
    @(posedge clk); #1;
    memenM = 1'b0; bus.bus_ack = 1'b0; bus.bus_rdata = $urandom;
    @(negedge clk);
    afterErr = buserrM; afterReq = bus.bus_req; afterStall = stallM;
  endtask

  // misaligned access held for three cycles
  task automatic accessMis(input logic [2:0] op, input logic [31:0] a);
    anyReq = 0; anyStall = 0;
    @(posedge clk); #1;
    memenM = 1'b1; memopM = op; aluoutM = a; writedataM = $urandom; bus.bus_ack = 1'b0;
    @(negedge clk);
    issAdel = adelM; issAdes = adesM;
    for (int c = 0; c < 3; c++) begin
      if (bus.bus_req) anyReq = 1;
      if (stallM) anyStall = 1;
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    memenM = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; memenM = 1'b0; memopM = 3'd0; aluoutM = 32'h0; writedataM = 32'h0;
    bus.bus_ack = 1'b0; bus.bus_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if ({bus.bus_req, bus.bus_we, buserrM} !== 3'b000)
      $display("FAIL reset_ctrl req/we/err=%b want 000", {bus.bus_req, bus.bus_we, buserrM}); else passCnt++;
    total++; if (bus.bus_addr !== 32'h0 || bus.bus_wstrb !== 4'h0 || bus.bus_wdata !== 32'h0)
      $display("FAIL reset_bus addr=%h strb=%b wdata=%h want zeros", bus.bus_addr, bus.bus_wstrb, bus.bus_wdata); else passCnt++;
    total++; if (readdataM !== 32'h0 || stallM !== 1'b0)
      $display("FAIL reset_rd readdata=%h stall=%b want 0/0", readdataM, stallM); else passCnt++;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_lw();
    access(3'd4, 32'h100, 32'h0, 32'hDEADBEEF, 2);
    total++; if (issStall !== 1'b1 || issReq !== 1'b0)
      $display("FAIL lw_issue stall=%b req=%b want 1/0", issStall, issReq); else passCnt++;
    total++; if (reqCycles !== 2 || stallCycles !== 3)
      $display("FAIL lw_latency req=%0d stall=%0d want 2/3", reqCycles, stallCycles); else passCnt++;
    total++; if (fAddr !== 32'h100 || fStrb !== 4'b0000 || fWe !== 1'b0)
      $display("FAIL lw_bus addr=%h strb=%b we=%b want 100/0000/0", fAddr, fStrb, fWe); else passCnt++;
    total++; if (doneRd !== 32'hDEADBEEF || doneStall !== 1'b0)
      $display("FAIL lw_done rd=%h stall=%b want deadbeef/0", doneRd, doneStall); else passCnt++;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    memenM = 1'b1; memopM = 3'd4; aluoutM = 32'h500; bus.bus_rdata = 32'h12345678;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.bus_req !== 1'b1)
      $display("FAIL rstmid_req_before got %b want 1", bus.bus_req); else passCnt++;
    @(posedge clk); #1;
    rst = 1'b0; memenM = 1'b0; bus.bus_ack = 1'b1;
    @(negedge clk);
    total++; if (bus.bus_req !== 1'b0 || readdataM !== 32'h0)
      $display("FAIL rstmid_after req=%b rd=%h want 0/0", bus.bus_req, readdataM); else passCnt++;
    @(posedge clk); #1;
    bus.bus_ack = 1'b0;
    @(negedge clk);
    total++; if (bus.bus_req !== 1'b0 || readdataM !== 32'h0 || buserrM !== 1'b0)
      $display("FAIL rstmid_ack_ignored req=%b rd=%h err=%b want 0/0/0", bus.bus_req, readdataM, buserrM); else passCnt++;
  endtask

  task automatic test_lb_lbu();
    access(3'd0, 32'h203, 32'h0, 32'h80112233, 1);
    total++; if (doneRd !== 32'hFFFFFF80 || fAddr !== 32'h200)
      $display("FAIL lb rd=%h addr=%h want ffffff80/200", doneRd, fAddr); else passCnt++;
    access(3'd1, 32'h203, 32'h0, 32'h80112233, 1);
    total++; if (doneRd !== 32'h00000080 || fAddr !== 32'h200)
      $display("FAIL lbu rd=%h addr=%h want 00000080/200", doneRd, fAddr); else passCnt++;
  endtask

  task automatic test_sh();
    access(3'd6, 32'h302, 32'h1234ABCD, 32'hFFFFFFFF, 1);
    total++; if (fStrb !== 4'b1100 || fWdata !== 32'hABCDABCD || fWe !== 1'b1)
      $display("FAIL sh_bus strb=%b wdata=%h we=%b want 1100/abcdabcd/1", fStrb, fWdata, fWe); else passCnt++;
    total++; if (doneRd !== 32'h0)
      $display("FAIL sh_rd got %h want 0", doneRd); else passCnt++;
  endtask

  task automatic test_misaligned();
    accessMis(3'd4, 32'h101);
    total++; if (issAdel !== 1'b1 || issAdes !== 1'b0 || anyStall || anyReq)
      $display("FAIL mis_lw adel=%b ades=%b stall=%b req=%b want 1/0/0/0", issAdel, issAdes, anyStall, anyReq); else passCnt++;
    accessMis(3'd6, 32'h301);
    total++; if (issAdel !== 1'b0 || issAdes !== 1'b1 || anyStall || anyReq)
      $display("FAIL mis_sh adel=%b ades=%b stall=%b req=%b want 0/1/0/0", issAdel, issAdes, anyStall, anyReq); else passCnt++;
  endtask

  task automatic test_timeout();
    access(3'd7, 32'h400, 32'hCAFEF00D, 32'h0, 0);
    total++; if (hung || reqCycles !== TO)
      $display("FAIL timeout_req hung=%0d reqcycles=%0d want 0/%0d", hung, reqCycles, TO); else passCnt++;
    total++; if (doneErr !== 1'b1 || afterErr !== 1'b0)
      $display("FAIL timeout_pulse done=%b after=%b want 1/0", doneErr, afterErr); else passCnt++;
    total++; if (doneStall !== 1'b0 || afterStall !== 1'b0 || afterReq !== 1'b0)
      $display("FAIL timeout_done stall=%b after_stall=%b after_req=%b want 0/0/0", doneStall, afterStall, afterReq); else passCnt++;
    total++; if (fStrb !== 4'hF || fWdata !== 32'hCAFEF00D)
      $display("FAIL timeout_bus strb=%b wdata=%h want 1111/cafef00d", fStrb, fWdata); else passCnt++;
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, wd, rd, expRd;
    int          ackAt, expReq;
    bit          tmo, st;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom & 32'h0000FFFF;
      wd = $urandom; rd = $urandom;
      ackAt = $urandom_range(0, 6);
      st = (op >= 3'd5);
      if (!mAligned(op, a)) begin
        accessMis(op, a);
        total++; if (issAdel !== !st || issAdes !== st || anyReq || anyStall)
          $display("FAIL rnd%0d_mis op=%0d a=%h adel=%b ades=%b req=%b stall=%b", i, op, a, issAdel, issAdes, anyReq, anyStall); else passCnt++;
      end else begin
        tmo    = (ackAt == 0) || (ackAt > TO);
        expReq = tmo ? TO : ackAt;
        expRd  = tmo ? 32'h0 : mLoad(op, a, rd);
        access(op, a, wd, rd, ackAt);
        total++; if (hung || reqCycles !== expReq || stallCycles !== expReq + 1 || !stable)
          $display("FAIL rnd%0d_timing op=%0d req=%0d stall=%0d stable=%0d want %0d/%0d/1", i, op, reqCycles, stallCycles, stable, expReq, expReq + 1); else passCnt++;
        total++; if (fAddr !== (a & ~32'h3) || fStrb !== mStrb(op, a) || fWe !== st || (st && fWdata !== mWdata(op, wd)))
          $display("FAIL rnd%0d_bus op=%0d a=%h addr=%h strb=%b we=%b wdata=%h want %h/%b/%b/%h", i, op, a, fAddr, fStrb, fWe, fWdata, a & ~32'h3, mStrb(op, a), st, mWdata(op, wd)); else passCnt++;
        total++; if (doneRd !== expRd || doneErr !== tmo || doneStall !== 1'b0 || afterErr !== 1'b0 || afterReq !== 1'b0)
          $display("FAIL rnd%0d_done op=%0d a=%h rd=%h err=%b stall=%b want %h/%b/0", i, op, a, doneRd, doneErr, doneStall, expRd, tmo); else passCnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_reset_mid();
    test_lb_lbu();
    test_sh();
    test_misaligned();
    test_timeout();
    test_random();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passCnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit (passed %0d of %0d)", passCnt, total);
    $fatal(1);
  end

endmodule
